// File: rtl/ir_tx_nec.sv
// NEC infrared transmitter with an Avalon-MM slave register interface.
// Generates the lead/bit/stop mark-space sequence for full frames and
// repeat codes. Marks are either modulated by a square-wave carrier or
// emitted as a plain envelope.
module ir_tx_nec #(
    parameter int UNIT_CYCLES = 28125,
    parameter int CARRIER_DIV = 1316
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        irq,
    output logic        ir_tx_export
);

    // The longest state (lead mark) lasts 16 units, so the duration counter
    // only has to hold 16*UNIT_CYCLES-1.
    localparam int CNT_W = $clog2(16 * UNIT_CYCLES);
    localparam int PH_W  = (CARRIER_DIV > 2) ? $clog2(CARRIER_DIV) : 1;

    // Each state's counter is loaded with (units*UNIT_CYCLES - 1) and then
    // counts down to zero.
    localparam logic [CNT_W-1:0] LOAD_1U  = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_3U  = CNT_W'(3 * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_4U  = CNT_W'(4 * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_8U  = CNT_W'(8 * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_16U = CNT_W'(16 * UNIT_CYCLES - 1);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CARRIER_DIV - 1);
    localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(CARRIER_DIV / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_STOP_MARK
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        bit_idx_q, bit_idx_d;
    logic              rep_q, rep_d;
    logic              carrier_q, carrier_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              tx_q, tx_d;
    logic [31:0]       data_q, data_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              busy;
    logic              wr_data, wr_status, wr_ctrl, wr_repeat;
    logic              start;
    logic              done_set;
    logic              mark_d;
    logic              mark_entry;

    // Register-select decode and transmission start qualification.
    always_comb begin
        wr_data   = avs_write && (avs_address == 2'd0);
        wr_status = avs_write && (avs_address == 2'd1);
        wr_ctrl   = avs_write && (avs_address == 2'd2);
        wr_repeat = avs_write && (avs_address == 2'd3);
        busy      = (state_q != S_IDLE);
        start     = (wr_data || wr_repeat) && !busy;
    end

    // Sequencer: next state, duration counter and bit index.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        rep_d     = rep_q;
        carrier_d = carrier_q;
        done_set  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_LEAD_MARK;
                    cnt_d     = LOAD_16U;
                    bit_idx_d = 5'd0;
                    rep_d     = wr_repeat;
                    // Carrier mode is frozen for the whole frame here.
                    carrier_d = ctrl_q[0];
                end
            end
            S_LEAD_MARK: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_LEAD_SPACE;
                    cnt_d   = rep_q ? LOAD_4U : LOAD_8U;
                end
            end
            S_LEAD_SPACE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = rep_q ? S_STOP_MARK : S_BIT_MARK;
                    cnt_d   = LOAD_1U;
                end
            end
            S_BIT_MARK: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_BIT_SPACE;
                    cnt_d   = data_q[bit_idx_q] ? LOAD_3U : LOAD_1U;
                end
            end
            S_BIT_SPACE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    cnt_d = LOAD_1U;
                    if (bit_idx_q == 5'd31) begin
                        state_d = S_STOP_MARK;
                    end else begin
                        state_d   = S_BIT_MARK;
                        bit_idx_d = bit_idx_q + 5'd1;
                    end
                end
            end
            S_STOP_MARK: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d  = S_IDLE;
                    done_set = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Carrier phase and LED drive, computed from the upcoming state so the
    // registered output lines up with the state it belongs to.
    always_comb begin
        mark_d     = (state_d == S_LEAD_MARK) || (state_d == S_BIT_MARK) ||
                     (state_d == S_STOP_MARK);
        mark_entry = mark_d && (state_d != state_q);
        phase_d    = '0;
        if (mark_d && !mark_entry) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
        end
        tx_d = mark_d && (carrier_d ? (phase_d < PH_HALF) : 1'b1);
    end

    // Register file: DATA/CTRL writes, sticky status flags and read mux.
    always_comb begin
        data_d    = (wr_data && !busy) ? avs_writedata : data_q;
        ctrl_d    = wr_ctrl ? avs_writedata[1:0] : ctrl_q;

        // A done event in the same cycle as its W1C clear keeps done set.
        done_d    = done_q;
        if (done_set) begin
            done_d = 1'b1;
        end else if (wr_status && avs_writedata[1]) begin
            done_d = 1'b0;
        end

        overrun_d = overrun_q;
        if ((wr_data || wr_repeat) && busy) begin
            overrun_d = 1'b1;
        end else if (wr_status && avs_writedata[2]) begin
            overrun_d = 1'b0;
        end

        rdata_d = rdata_q;
        if (avs_read) begin
            case (avs_address)
                2'd0:    rdata_d = data_q;
                2'd1:    rdata_d = {29'd0, overrun_q, done_q, busy};
                2'd2:    rdata_d = {30'd0, ctrl_q};
                default: rdata_d = 32'd0;
            endcase
        end
    end

    // State register for sequencer, carrier, output and registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 5'd0;
            rep_q     <= 1'b0;
            carrier_q <= 1'b0;
            phase_q   <= '0;
            tx_q      <= 1'b0;
            data_q    <= 32'd0;
            ctrl_q    <= 2'd0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            rep_q     <= rep_d;
            carrier_q <= carrier_d;
            phase_q   <= phase_d;
            tx_q      <= tx_d;
            data_q    <= data_d;
            ctrl_q    <= ctrl_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            rdata_q   <= rdata_d;
        end
    end

    assign avs_readdata = rdata_q;
    assign ir_tx_export = tx_q;
    assign irq          = done_q & ctrl_q[1];

endmodule
